// File: rtl/hamming_scrub_ctrl.sv
// hamming_scrub_ctrl: front-end for a hamming_reg.
// Keeps a golden shadow of the last user write. It periodically reads back the
// corrected register and compares it against the shadow. It then rewrites the
// shadow so that accumulated single-bit upsets are cleared. Readback mismatches
// are counted.
module hamming_scrub_ctrl #(
   parameter int data_width   = 8,
   parameter int scrub_period = 1024,
   parameter int cnt_width    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  user_wr_valid,
   output logic                  user_wr_ready,
   input  logic [data_width-1:0] user_wdata,
   input  logic                  scrub_en,
   input  logic                  clr_stats,
   output logic                  reg_wren,
   output logic [data_width-1:0] reg_wdata,
   input  logic [data_width-1:0] reg_rdata,
   output logic [data_width-1:0] rdata,
   output logic                  mismatch_flag,
   output logic [cnt_width-1:0]  mismatch_count,
   output logic [cnt_width-1:0]  scrub_count,
   output logic                  scrub_busy
);

   localparam int iw = (scrub_period > 2) ? $clog2(scrub_period) : 1;
   localparam logic [iw-1:0] reload_val = iw'(scrub_period - 1);
   localparam logic [cnt_width-1:0] cnt_max = '1;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      WRITEBACK
   } state_t;

   state_t                state_q, state_d;
   logic [data_width-1:0] shadow_q, shadow_d;
   logic [iw-1:0]         interval_q, interval_d;
   logic                  pending_q, pending_d;
   logic [cnt_width-1:0]  mismatch_count_q, mismatch_count_d;
   logic [cnt_width-1:0]  scrub_count_q, scrub_count_d;
   logic                  mismatch_flag_q, mismatch_flag_d;
   logic                  accept;
   logic                  interval_hit;
   logic                  mismatch;

   // FSM next state and register-port drive; a user write in IDLE beats a pending scrub
   always_comb begin
      state_d       = state_q;
      user_wr_ready = 1'b0;
      reg_wren      = 1'b0;
      reg_wdata     = '0;
      accept        = 1'b0;
      case (state_q)
         IDLE: begin
            user_wr_ready = 1'b1;
            if (user_wr_valid) begin
               accept    = 1'b1;
               reg_wren  = 1'b1;
               reg_wdata = user_wdata;
            end else if (pending_q) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            state_d = WRITEBACK;
         end
         WRITEBACK: begin
            reg_wren  = 1'b1;
            reg_wdata = shadow_q;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Shadow capture, scrub interval timer and pending request; a reload that lands on the writeback cycle re-arms the request
   always_comb begin
      shadow_d     = accept ? user_wdata : shadow_q;
      interval_hit = scrub_en && (interval_q == '0);
      interval_d   = interval_q;
      if (scrub_en) begin
         interval_d = interval_hit ? reload_val : interval_q - 1'b1;
      end
      pending_d = pending_q;
      if (state_q == WRITEBACK) begin
         pending_d = 1'b0;
      end
      if (interval_hit) begin
         pending_d = 1'b1;
      end
   end

   // Saturating statistics; clr_stats wins over a same-cycle increment
   always_comb begin
      mismatch         = (state_q == CHECK) && (reg_rdata != shadow_q);
      mismatch_count_d = mismatch_count_q;
      scrub_count_d    = scrub_count_q;
      mismatch_flag_d  = mismatch_flag_q;
      if (clr_stats) begin
         mismatch_count_d = '0;
         scrub_count_d    = '0;
         mismatch_flag_d  = 1'b0;
      end else begin
         if (mismatch) begin
            mismatch_flag_d = 1'b1;
            if (mismatch_count_q != cnt_max) begin
               mismatch_count_d = mismatch_count_q + 1'b1;
            end
         end
         if ((state_q == WRITEBACK) && (scrub_count_q != cnt_max)) begin
            scrub_count_d = scrub_count_q + 1'b1;
         end
      end
   end

   // State registers; reset leaves shadow at 0 to match the register's own reset value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         shadow_q         <= '0;
         interval_q       <= reload_val;
         pending_q        <= 1'b0;
         mismatch_count_q <= '0;
         scrub_count_q    <= '0;
         mismatch_flag_q  <= 1'b0;
      end else begin
         state_q          <= state_d;
         shadow_q         <= shadow_d;
         interval_q       <= interval_d;
         pending_q        <= pending_d;
         mismatch_count_q <= mismatch_count_d;
         scrub_count_q    <= scrub_count_d;
         mismatch_flag_q  <= mismatch_flag_d;
      end
   end

   assign rdata          = reg_rdata;
   assign scrub_busy     = (state_q != IDLE);
   assign mismatch_flag  = mismatch_flag_q;
   assign mismatch_count = mismatch_count_q;
   assign scrub_count    = scrub_count_q;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Testbench for hamming_scrub_ctrl.
// The attached hamming_reg is represented by a plain storage word. Upsets that
// the Hamming code cannot correct are modelled by flipping bits of that word.
// The reference model tracks the controller by cycle. It uses phase numbers, a
// count of enabled cycles, and the shadow/register contents.
module tb_hamming_scrub_ctrl;

   localparam int DW   = 8;
   localparam int PER  = 16;
   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          user_wr_valid = 1'b0;
   logic          user_wr_ready;
   logic [DW-1:0] user_wdata = '0;
   logic          scrub_en = 1'b0;
   logic          clr_stats = 1'b0;
   logic          reg_wren;
   logic [DW-1:0] reg_wdata;
   logic [DW-1:0] reg_val = '0;
   logic [DW-1:0] rdata;
   logic          mismatch_flag;
   logic [CW-1:0] mismatch_count;
   logic [CW-1:0] scrub_count;
   logic          scrub_busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int          m_phase;
   int          m_en_count;
   bit          m_pending;
   logic [DW-1:0] m_shadow;
   logic [DW-1:0] m_reg;
   int          m_mm;
   int          m_sc;
   bit          m_flag;

   // Sampled register-port drive, used by the storage model at the next edge
   logic          s_wren;
   logic [DW-1:0] s_wdata;

   wire [23:0] act_vec = {user_wr_ready, reg_wren, reg_wdata, scrub_busy, rdata,
                          mismatch_flag, mismatch_count, scrub_count};

   hamming_scrub_ctrl #(
      .data_width(DW),
      .scrub_period(PER),
      .cnt_width(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .user_wr_valid(user_wr_valid),
      .user_wr_ready(user_wr_ready),
      .user_wdata(user_wdata),
      .scrub_en(scrub_en),
      .clr_stats(clr_stats),
      .reg_wren(reg_wren),
      .reg_wdata(reg_wdata),
      .reg_rdata(reg_val),
      .rdata(rdata),
      .mismatch_flag(mismatch_flag),
      .mismatch_count(mismatch_count),
      .scrub_count(scrub_count),
      .scrub_busy(scrub_busy)
   );

   // Free-running clock
   always #5 clk = ~clk;

   function automatic int sat_inc(input int v);
      return (v < MAXC) ? v + 1 : MAXC;
   endfunction

   // Expected outputs for the current model state and current inputs
   function automatic logic [23:0] model_out();
      bit            rdy, acc, wr, busy;
      logic [DW-1:0] wd;
      rdy  = (m_phase == 0);
      acc  = user_wr_valid && rdy;
      wr   = acc || (m_phase == 2);
      wd   = acc ? user_wdata : ((m_phase == 2) ? m_shadow : '0);
      busy = (m_phase != 0);
      return {rdy, wr, wd, busy, m_reg, m_flag, CW'(m_mm), CW'(m_sc)};
   endfunction

   task automatic model_reset();
      m_phase    = 0;
      m_en_count = 0;
      m_pending  = 0;
      m_shadow   = '0;
      m_reg      = '0;
      m_mm       = 0;
      m_sc       = 0;
      m_flag     = 0;
   endtask

   // One clock edge of the behavioural reference
   task automatic model_step();
      bit            acc, wr, hit;
      int            nxt;
      logic [DW-1:0] wd;
      if (!reset) begin
         model_reset();
         return;
      end
      acc = user_wr_valid && (m_phase == 0);
      wr  = acc || (m_phase == 2);
      wd  = acc ? user_wdata : m_shadow;
      if (clr_stats) begin
         m_mm = 0; m_sc = 0; m_flag = 0;
      end else begin
         if (m_phase == 1 && m_reg != m_shadow) begin
            m_mm = sat_inc(m_mm); m_flag = 1;
         end
         if (m_phase == 2) m_sc = sat_inc(m_sc);
      end
      hit = 0;
      if (scrub_en) begin
         m_en_count++;
         hit = (m_en_count % PER) == 0;
      end
      case (m_phase)
         0: nxt = (m_pending && !acc) ? 1 : 0;
         1: nxt = 2;
         default: nxt = 0;
      endcase
      if (m_phase == 2) m_pending = 0;
      if (hit) m_pending = 1;
      m_phase = nxt;
      if (wr) m_reg = wd;
      if (acc) m_shadow = user_wdata;
   endtask

   // Advance one clock: model and storage word update, then return at the falling edge
   task automatic cycle();
      s_wren  = reg_wren;
      s_wdata = reg_wdata;
      @(posedge clk);
      model_step();
      #1;
      if (!reset) reg_val = '0;
      else if (s_wren) reg_val = s_wdata;
      @(negedge clk);
   endtask

   task automatic upset(input logic [DW-1:0] mask);
      reg_val = reg_val ^ mask;
      m_reg   = m_reg ^ mask;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0; user_wr_valid = 0; scrub_en = 0; clr_stats = 0;
      reg_val = '0;
      model_reset();
      #1;
      n_checks++;
      if (act_vec !== 24'h800000) begin
         n_fail++;
         $display("[TB] FAIL reset_state: got %h expected %h", act_vec, 24'h800000);
      end
      cycle(); cycle();
      reset = 1'b1;
      scrub_en = 1'b1;
   endtask

   task automatic test_idle_scrub();
      int first_busy;
      first_busy = -1;
      for (int c = 0; c < 2 * PER + 4; c++) begin
         #1;
         n_checks++;
         if (act_vec !== model_out()) begin
            n_fail++;
            $display("[TB] FAIL idle_scrub c%0d: got %h expected %h", c, act_vec, model_out());
         end
         if (scrub_busy && first_busy < 0) first_busy = c;
         cycle();
      end
      n_checks++;
      if (first_busy < 0) begin
         n_fail++;
         $display("[TB] FAIL idle_scrub_seen: got busy never expected busy within %0d cycles", 2 * PER + 4);
      end
   endtask

   task automatic test_write();
      for (int c = 0; c < PER + 6; c++) begin
         user_wr_valid = (c == 0) && (m_phase == 0);
         user_wdata    = 8'hA5;
         #1;
         n_checks++;
         if (act_vec !== model_out()) begin
            n_fail++;
            $display("[TB] FAIL write c%0d: got %h expected %h", c, act_vec, model_out());
         end
         cycle();
         if (c == 0) begin
            n_checks++;
            if (rdata !== 8'hA5) begin
               n_fail++;
               $display("[TB] FAIL write_visible: got %h expected a5", rdata);
            end
         end
      end
      user_wr_valid = 0;
   endtask

   task automatic test_double_upset();
      int guard;
      guard = 0;
      while (m_phase != 1 && guard < 4 * PER) begin
         #1;
         n_checks++;
         if (act_vec !== model_out()) begin
            n_fail++;
            $display("[TB] FAIL dbl_wait: got %h expected %h", act_vec, model_out());
         end
         cycle(); guard++;
      end
      if (m_phase != 1) begin
         n_fail++;
         $display("[TB] FAIL dbl_timeout: got no CHECK expected CHECK within %0d cycles", 4 * PER);
      end
      upset(8'h81);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (act_vec !== model_out()) begin
            n_fail++;
            $display("[TB] FAIL dbl_scrub c%0d: got %h expected %h", c, act_vec, model_out());
         end
         cycle();
      end
      n_checks++;
      if (mismatch_flag !== 1'b1 || rdata !== m_shadow) begin
         n_fail++;
         $display("[TB] FAIL dbl_result: got flag=%b rdata=%h expected flag=1 rdata=%h",
                  mismatch_flag, rdata, m_shadow);
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 3 * PER + 6; c++) begin
         user_wr_valid = (c < 3 * PER);
         user_wdata    = DW'($urandom);
         #1;
         n_checks++;
         if (act_vec !== model_out()) begin
            n_fail++;
            $display("[TB] FAIL b2b c%0d: got %h expected %h", c, act_vec, model_out());
         end
         cycle();
      end
      user_wr_valid = 0;
   endtask

   task automatic test_saturation();
      int guard;
      clr_stats = 1; #1; cycle(); clr_stats = 0;
      for (int k = 0; k < 6; k++) begin
         guard = 0;
         while (m_phase != 1 && guard < 4 * PER) begin
            #1;
            n_checks++;
            if (act_vec !== model_out()) begin
               n_fail++;
               $display("[TB] FAIL sat_wait k%0d: got %h expected %h", k, act_vec, model_out());
            end
            cycle(); guard++;
         end
         if (m_phase != 1) begin
            n_fail++;
            $display("[TB] FAIL sat_timeout: got no CHECK expected CHECK k%0d", k);
         end
         upset(8'h3C);
         clr_stats = (k == 5);
         #1;
         n_checks++;
         if (act_vec !== model_out()) begin
            n_fail++;
            $display("[TB] FAIL sat_check k%0d: got %h expected %h", k, act_vec, model_out());
         end
         cycle();
         clr_stats = 0;
         if (k == 4) begin
            n_checks++;
            if (mismatch_count !== 2'd3) begin
               n_fail++;
               $display("[TB] FAIL sat_count: got %0d expected 3", mismatch_count);
            end
         end
      end
      n_checks++;
      if (mismatch_count !== 2'd0 || mismatch_flag !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL sat_clear: got cnt=%0d flag=%b expected cnt=0 flag=0",
                  mismatch_count, mismatch_flag);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         user_wr_valid = ($urandom_range(0, 1) == 1);
         user_wdata    = DW'($urandom);
         scrub_en      = ($urandom_range(0, 9) < 8);
         clr_stats     = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 24) == 0) upset(DW'($urandom) | 8'h01);
         #1;
         n_checks++;
         if (act_vec !== model_out()) begin
            n_fail++;
            $display("[TB] FAIL random c%0d: got %h expected %h", c, act_vec, model_out());
         end
         cycle();
      end
      user_wr_valid = 0; clr_stats = 0; scrub_en = 1;
   endtask

   task automatic test_reset_mid_scrub();
      int guard;
      guard = 0;
      while (m_phase != 1 && guard < 4 * PER) begin
         #1; cycle(); guard++;
      end
      if (m_phase != 1) begin
         n_fail++;
         $display("[TB] FAIL rst_mid_timeout: got no CHECK expected CHECK");
      end
      reset = 1'b0;
      reg_val = '0;
      model_reset();
      #1;
      n_checks++;
      if (act_vec !== model_out()) begin
         n_fail++;
         $display("[TB] FAIL rst_mid: got %h expected %h", act_vec, model_out());
      end
      cycle();
      reset = 1'b1;
      for (int c = 0; c < PER + 4; c++) begin
         #1;
         n_checks++;
         if (act_vec !== model_out()) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_after c%0d: got %h expected %h", c, act_vec, model_out());
         end
         cycle();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_idle_scrub();
      test_write();
      test_double_upset();
      test_back_to_back();
      test_saturation();
      test_random();
      test_reset_mid_scrub();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
